rst_code_decoder: RTL

- Backend-side receiver for the serial reset code the sync board drives on m_rst alongside the forwarded 100 MHz clock.
- The code is one 4-bit frame per 4 clocks, MSB first: IDLE = 4'b1010, ACTIVE = 4'b1100.
- Finds frame alignment, declares lock, and decodes ACTIVE frames into a one-cycle rst_pulse and a stretched rst_out.
- Counts framing errors.
- Sits directly after the backend IBUFDS/IDDR sampling of m_rst_p/n, in the forwarded clk_100 domain.

---
 rtl/rst_code_pkg.sv | 19 +
 rtl/rst_code_decoder_if.sv | 24 ++
 rtl/rst_stretch.sv | 35 +++
 rtl/rst_code_decoder.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/rst_code_pkg.sv
// Shared reset-code definitions for the sync-board generator and the backend decoder.
// Both sides import this package so the frame codes cannot drift apart.
package rst_code_pkg;

  localparam int RST_BITS = 4;
  localparam logic [RST_BITS-1:0] RST_IDLE   = 4'b1010;
  localparam logic [RST_BITS-1:0] RST_ACTIVE = 4'b1100;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic code_valid(input logic [RST_BITS-1:0] code);
    return (code == RST_IDLE) || (code == RST_ACTIVE);
  endfunction

endpackage

// File: rtl/rst_code_decoder_if.sv
// Reset-code link between the sampled serial input and the decoded backend reset outputs.
interface rst_code_decoder_if #(
  parameter int CNT_W = 16
);

  logic             rst_ser_in;
  logic             rst_pulse;
  logic             rst_out;
  logic             locked;
  logic             frame_err;
  logic [CNT_W-1:0] err_count;
  logic [1:0]       phase;

  modport master (
    output rst_ser_in,
    input  rst_pulse, rst_out, locked, frame_err, err_count, phase
  );

  modport slave (
    input  rst_ser_in,
    output rst_pulse, rst_out, locked, frame_err, err_count, phase
  );

endinterface

// File: rtl/rst_stretch.sv
// Reload/decrement stretcher: holds rst_out high for STRETCH cycles after the last load
// and after reset release.
module rst_stretch #(
  parameter int STRETCH = 16
) (
  input  logic clk_100,
  input  logic rst_n,
  input  logic load,
  output logic rst_out
);

  localparam int SW = $clog2(STRETCH + 1);
  localparam logic [SW-1:0] RELOAD = SW'(STRETCH);
  localparam logic [SW-1:0] ONE    = SW'(1);

  logic [SW-1:0] count;

  // Stretch counter; rst_out drops in the same cycle the count reaches zero
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      count   <= RELOAD;
      rst_out <= 1'b1;
    end else if (load) begin
      count   <= RELOAD;
      rst_out <= 1'b1;
    end else if (count != '0) begin
      count   <= count - ONE;
      rst_out <= (count != ONE);
    end else begin
      count   <= count;
      rst_out <= 1'b0;
    end
  end

endmodule

// File: rtl/rst_code_decoder.sv
// Backend receiver for the serial reset code: frame alignment, lock tracking,
// ACTIVE-frame decode into rst_pulse/rst_out, and framing-error counting.
module rst_code_decoder
  import rst_code_pkg::*;
#(
  parameter int LOCK_FRAMES = 8,
  parameter int ERR_LIMIT   = 4,
  parameter int STRETCH     = 16,
  parameter int CNT_W       = 16
) (
  input logic               clk_100,
  input logic               rst_n,
  rst_code_decoder_if.slave bus
);

  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
  localparam int ERRC_W = $clog2(ERR_LIMIT + 1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_FRAMES);
  localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
  localparam logic [ERRC_W-1:0] ERRC_LIM  = ERRC_W'(ERR_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t              state;
  logic [RST_BITS-1:0] sr;
  logic [RST_BITS-1:0] sr_next;
  logic [1:0]          cnt;
  logic [1:0]          phase;
  logic [1:0]          alt_phase;
  logic [GOOD_W-1:0]   good;
  logic [ERRC_W-1:0]   errc;
  logic                pend;
  logic                rst_pulse;
  logic                locked;
  logic                frame_err;
  logic [CNT_W-1:0]    err_count;
  logic                boundary;
  logic                recheck;
  logic                fire;
  logic                rst_out;

  assign sr_next   = {sr[RST_BITS-2:0], bus.rst_ser_in};
  assign alt_phase = phase + 2'd2;
  assign boundary  = (cnt == phase);
  // IDLE is 2-periodic, so a bad frame may just mean we locked two bits off
  assign recheck   = pend && (cnt == alt_phase);
  assign fire      = (state == LOCKED) && (sr_next == RST_ACTIVE) && (boundary || recheck);

  // Frame alignment, lock and error-tracking state machine
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      sr        <= '0;
      cnt       <= 2'd0;
      phase     <= 2'd0;
      good      <= '0;
      errc      <= '0;
      pend      <= 1'b0;
      rst_pulse <= 1'b0;
      locked    <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      sr        <= sr_next;
      cnt       <= cnt + 2'd1;
      rst_pulse <= fire;
      frame_err <= 1'b0;
      case (state)
        HUNT: begin
          if (code_valid(sr_next)) begin
            phase <= cnt;
            good  <= GOOD_ONE;
            state <= CHECK;
          end else begin
            good <= '0;
          end
        end
        CHECK: begin
          if (boundary) begin
            if (code_valid(sr_next)) begin
              good <= good + 1'b1;
              if (good + 1'b1 == GOOD_LOCK) begin
                state  <= LOCKED;
                locked <= 1'b1;
                errc   <= '0;
                pend   <= 1'b0;
              end
            end else begin
              state <= HUNT;
              good  <= '0;
            end
          end
        end
        LOCKED: begin
          if (recheck) begin
            pend <= 1'b0;
            if (sr_next == RST_ACTIVE) begin
              phase <= alt_phase;
              errc  <= '0;
            end else begin
              frame_err <= 1'b1;
              if (err_count != CNT_MAX) begin
                err_count <= err_count + 1'b1;
              end
              if (errc + 1'b1 == ERRC_LIM) begin
                state  <= HUNT;
                locked <= 1'b0;
                errc   <= '0;
              end else begin
                errc <= errc + 1'b1;
              end
            end
          end else if (boundary) begin
            if (code_valid(sr_next)) begin
              errc <= '0;
            end else begin
              pend <= 1'b1;
            end
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
          pend   <= 1'b0;
        end
      endcase
    end
  end

  rst_stretch #(
    .STRETCH(STRETCH)
  ) u_stretch (
    .clk_100(clk_100),
    .rst_n  (rst_n),
    .load   (fire),
    .rst_out(rst_out)
  );

  assign bus.rst_pulse = rst_pulse;
  assign bus.rst_out   = rst_out;
  assign bus.locked    = locked;
  assign bus.frame_err = frame_err;
  assign bus.err_count = err_count;
  assign bus.phase     = phase;

endmodule
